// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM encoding for the UART transmit feeder.
package uart_tx_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_ARM_TIMEOUT = 8;
    localparam int unsigned DEF_GAP_CYCLES  = 32;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARM       = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Upstream byte stream (valid/ready) into the UART transmit feeder.
interface uart_tx_feeder_if;
    import uart_tx_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, fill level and synchronous flush.
module sync_fifo #(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    // Flush dominates a simultaneous push.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers upstream bytes and hands them one at a time to uart_send,
// enforcing a guard gap after each frame so every uart_en rise is fresh.
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int unsigned  DEPTH       = DEF_DEPTH,
    parameter int unsigned  ARM_TIMEOUT = DEF_ARM_TIMEOUT,
    parameter int unsigned  GAP_CYCLES  = DEF_GAP_CYCLES,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_tx_feeder_if.slave   in_if,
    input  logic              flush,
    output logic [ADDR_W:0]   fifo_level,
    output logic              uart_en,
    output logic [BYTE_W-1:0] uart_din,
    input  logic              uart_tx_busy,
    output logic              idle,
    output logic              tx_err
);

    localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]        state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              uart_en_d;
    logic [BYTE_W-1:0] uart_din_d;
    logic              tx_err_d;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;

    sync_fifo #(
        .DATA_W (BYTE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .push    (in_if.in_valid),
        .wr_data (in_if.in_data),
        .pop     (pop_c),
        .flush   (flush),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_if.in_ready = ~fifo_full;
    assign idle           = fifo_empty && (state_q == ST_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            arm_cnt_q <= '0;
            gap_cnt_q <= '0;
            uart_en   <= 1'b0;
            uart_din  <= '0;
            tx_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            uart_en   <= uart_en_d;
            uart_din  <= uart_din_d;
            tx_err    <= tx_err_d;
        end
    end

    // Frame sequencing: launch, wait for busy, wait for done, guard gap.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        uart_en_d  = uart_en;
        uart_din_d = uart_din;
        tx_err_d   = 1'b0;
        pop_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !uart_tx_busy) begin
                    pop_c      = 1'b1;
                    uart_din_d = fifo_head;
                    uart_en_d  = 1'b1;
                    arm_cnt_d  = '0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (uart_tx_busy) begin
                    uart_en_d = 1'b0;
                    state_d   = ST_WAIT_DONE;
                end else if (arm_cnt_q + ARM_W'(1) == ARM_W'(ARM_TIMEOUT)) begin
                    // Transmitter never responded: drop the byte, still honour the gap.
                    tx_err_d  = 1'b1;
                    uart_en_d = 1'b0;
                    gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                    state_d   = ST_GAP;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d   = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural uart_send responder.
module tb_uart_tx_feeder;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       flush;
    logic [4:0] fifo_level;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_tx_busy;
    logic       idle;
    logic       tx_err;

    uart_tx_feeder_if in_if ();

    uart_tx_feeder dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .in_if        (in_if),
        .flush        (flush),
        .fifo_level   (fifo_level),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy),
        .idle         (idle),
        .tx_err       (tx_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // uart_send model: busy rises 2 cycles after a uart_en rise, held hold_len cycles.
    logic        model_busy, busy_hold, model_on, en_prev, pend;
    int unsigned hold_len, bcnt;
    assign uart_tx_busy = model_busy | busy_hold;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            model_busy <= 1'b0;
            en_prev    <= 1'b0;
            pend       <= 1'b0;
            bcnt       <= 0;
        end else begin
            en_prev <= uart_en;
            pend    <= model_on && uart_en && !en_prev;
            if (pend) begin
                model_busy <= 1'b1;
                bcnt       <= hold_len - 1;
            end else if (model_busy) begin
                if (bcnt == 0) model_busy <= 1'b0;
                else           bcnt       <= bcnt - 1;
            end
        end
    end

    // Observer: bytes launched, spacing from last busy fall, error pulses.
    logic [7:0] rise_q[$];
    int         cyc, fall_cyc, min_gap, err_cnt;
    logic       fall_valid, en_seen, busy_seen;

    initial begin
        cyc = 0; fall_cyc = 0; min_gap = 1000; err_cnt = 0;
        fall_valid = 1'b0; en_seen = 1'b0; busy_seen = 1'b0;
    end

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (uart_en && !en_seen) begin
            rise_q.push_back(uart_din);
            if (fall_valid && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
        end
        en_seen = uart_en;
        if (!model_busy && busy_seen) begin
            fall_cyc   = cyc;
            fall_valid = 1'b1;
        end
        busy_seen = model_busy;
        if (tx_err) err_cnt = err_cnt + 1;
    end

    int n_pass, n_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (in_if.in_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("push_ready", 32'(in_if.in_ready), 1);
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        tick();
        in_if.in_valid = 1'b0;
    endtask

    initial begin
        int n, bad, base;
        n_pass = 0; n_total = 0;
        sys_rst_n = 1'b0; flush = 1'b0;
        in_if.in_valid = 1'b0; in_if.in_data = 8'h00;
        busy_hold = 1'b0; model_on = 1'b1; hold_len = 4340;

        // Reset values
        repeat (3) tick();
        sys_rst_n = 1'b1;
        check("rst_uart_en",  32'(uart_en), 0);
        check("rst_uart_din", 32'(uart_din), 0);
        check("rst_tx_err",   32'(tx_err), 0);
        check("rst_level",    32'(fifo_level), 0);
        check("rst_in_ready", 32'(in_if.in_ready), 1);
        check("rst_idle",     32'(idle), 1);

        // Single frame, long busy
        repeat (6) tick();
        push(8'h55);
        check("t1_en_at_push", 32'(uart_en), 0);
        check("t1_level_push", 32'(fifo_level), 1);
        check("t1_idle_push",  32'(idle), 0);
        tick();
        check("t1_en_rise", 32'(uart_en), 1);
        check("t1_din",     32'(uart_din), 32'h55);
        check("t1_level",   32'(fifo_level), 0);
        n = 0;
        while (!uart_tx_busy && n < 10) begin tick(); n++; end
        check("t1_busy_latency", 32'(n), 2);
        check("t1_en_at_busy", 32'(uart_en), 1);
        tick();
        check("t1_en_fall", 32'(uart_en), 0);
        bad = 0; n = 0;
        while (uart_tx_busy && n < 5000) begin
            if (uart_din !== 8'h55 || uart_en !== 1'b0) bad++;
            tick(); n++;
        end
        check("t1_busy_len", 32'(n), 4339);
        check("t1_din_stable", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (idle !== 1'b0) bad++;
            tick();
        end
        check("t1_gap_not_idle", 32'(bad), 0);
        check("t1_idle_after_gap", 32'(idle), 1);

        // Burst of 16 while transmitter busy, 17th refused
        hold_len = 20;
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_level_full", 32'(fifo_level), 16);
        check("t2_in_ready",   32'(in_if.in_ready), 0);
        check("t2_idle",       32'(idle), 0);
        in_if.in_valid = 1'b1; in_if.in_data = 8'hEE;
        tick();
        in_if.in_valid = 1'b0;
        check("t2_level_17th", 32'(fifo_level), 16);
        rise_q.delete(); fall_valid = 1'b0; min_gap = 1000;
        busy_hold = 1'b0;
        n = 0;
        while (rise_q.size() < 16 && n < 3000) begin tick(); n++; end
        check("t2_frames", 32'(rise_q.size()), 16);
        for (int i = 0; i < 16 && i < rise_q.size(); i++)
            check("t2_order", 32'(rise_q[i]), 32'(i));
        n = 0;
        while (!idle && n < 200) begin tick(); n++; end
        repeat (40) tick();
        check("t2_no_17th", 32'(rise_q.size()), 16);
        check("t2_min_gap_ge33", 32'(min_gap >= 33), 1);

        // ARM timeout with a dead transmitter
        model_on = 1'b0; err_cnt = 0; base = rise_q.size();
        push(8'hA5);
        tick();
        check("t3_en_rise", 32'(uart_en), 1);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (tx_err !== 1'b0) bad++;
        end
        check("t3_no_early_err", 32'(bad), 0);
        tick();
        check("t3_tx_err", 32'(tx_err), 1);
        check("t3_en_drop", 32'(uart_en), 0);
        tick();
        check("t3_err_pulse_end", 32'(tx_err), 0);
        repeat (30) tick();
        check("t3_gap_not_idle", 32'(idle), 0);
        tick();
        check("t3_idle", 32'(idle), 1);
        repeat (20) tick();
        check("t3_err_count", 32'(err_cnt), 1);
        check("t3_no_retry", 32'(rise_q.size()), 32'(base + 1));

        // Flush while a frame is in WAIT_DONE, with a push in the flush cycle
        model_on = 1'b1; base = rise_q.size();
        for (int i = 0; i < 6; i++) push(8'(16 + i));
        check("t4_level_pre", 32'(fifo_level), 5);
        check("t4_en_waitdone", 32'(uart_en), 0);
        flush = 1'b1; in_if.in_valid = 1'b1; in_if.in_data = 8'h99;
        tick();
        flush = 1'b0; in_if.in_valid = 1'b0;
        check("t4_level_flush", 32'(fifo_level), 0);
        check("t4_din_held", 32'(uart_din), 32'h10);
        n = 0;
        while (uart_tx_busy && n < 100) begin tick(); n++; end
        check("t4_busy_done", 32'(uart_tx_busy), 0);
        repeat (60) tick();
        check("t4_idle", 32'(idle), 1);
        check("t4_one_frame", 32'(rise_q.size()), 32'(base + 1));

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) push(8'(48 + i));
        n = 0;
        while (!uart_tx_busy && n < 10) begin tick(); n++; end
        check("t5_level_pre", 32'(fifo_level), 3);
        sys_rst_n = 1'b0;
        #1;
        check("t5_rst_en",       32'(uart_en), 0);
        check("t5_rst_din",      32'(uart_din), 0);
        check("t5_rst_err",      32'(tx_err), 0);
        check("t5_rst_level",    32'(fifo_level), 0);
        check("t5_rst_idle",     32'(idle), 1);
        check("t5_rst_in_ready", 32'(in_if.in_ready), 1);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // Push+pop at level 7, then 40 bytes through pointer wrap
        hold_len = 3; busy_hold = 1'b1;
        rise_q.delete(); fall_valid = 1'b0; min_gap = 1000;
        for (int i = 0; i < 7; i++) push(8'(128 + i));
        check("t6_level7", 32'(fifo_level), 7);
        busy_hold = 1'b0;
        in_if.in_valid = 1'b1; in_if.in_data = 8'h87;
        tick();
        in_if.in_valid = 1'b0;
        check("t6_level_pushpop", 32'(fifo_level), 7);
        check("t6_en", 32'(uart_en), 1);
        check("t6_din", 32'(uart_din), 32'h80);
        for (int i = 8; i < 40; i++) push(8'(128 + i));
        n = 0;
        while (rise_q.size() < 40 && n < 5000) begin tick(); n++; end
        check("t6_frames", 32'(rise_q.size()), 40);
        bad = 0;
        for (int i = 0; i < rise_q.size(); i++)
            if (rise_q[i] !== 8'(128 + i)) bad++;
        check("t6_wrap_order", 32'(bad), 0);
        check("t6_min_gap_ge33", 32'(min_gap >= 33), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
